// File: rtl/amc_frame_sched_pkg.sv
// amc_pkg: shared types for the frame-boundary AMC scheduler.
//   amc_mode_e     - modulation modes understood by the mapper
//   sched_state_e  - scheduler FSM states
//   amc_mode_legal - true for modes the mapper implements (BPSK, QPSK)
package amc_pkg;

  localparam int unsigned MODE_W       = 3;
  localparam int unsigned SETTLE_CNT_W = 4;

  typedef enum logic [MODE_W-1:0] {
    AMC_BPSK = 3'd0,
    AMC_QPSK = 3'd1
  } amc_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_APPLY  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_PASS   = 2'd3
  } sched_state_e;

  function automatic logic amc_mode_legal(input logic [MODE_W-1:0] mode);
    return (mode == AMC_BPSK) || (mode == AMC_QPSK);
  endfunction

endpackage

// File: rtl/amc_frame_sched_fifo.sv
// amc_mode_fifo: synchronous FIFO holding pending per-frame mode requests.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset (flushes the FIFO)
//   push_i, din_i    write strobe / data (ignored when full)
//   pop_i, dout_o    read strobe (ignored when empty) / head entry
//   full_o, empty_o  occupancy flags
//   count_o          occupancy, one bit wider than the pointers
module amc_mode_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/amc_frame_sched.sv
// amc_frame_sched: applies queued AMC mode requests to the mapper only on
// frame boundaries, waits a settle interval, then passes one TLAST-terminated
// byte frame from upstream to the mapper.
// Ports:
//   clk_bb, rst                         clock, synchronous active-high reset
//   req_mode/req_valid/req_ready        mode request queue input
//   s_valid/s_ready/s_data/s_last       upstream byte stream
//   m_valid/m_ready/m_data/m_last       mapper byte stream
//   amc_mode_o/amc_mode_valid_o         mode to mapper, one-cycle apply pulse
//   cur_mode                            mode of the frame in flight
//   err_bad_mode                        sticky: a reserved mode was popped
//   busy                                FSM not in IDLE
// Optional build macro AMC_FRAME_SCHED_STATS_EN adds stat_frames,
// stat_bytes and stat_def_used counters (all wrap, reset to 0).
//
// state  | meaning
// IDLE   | waiting for the first byte of a frame; upstream stalled
// APPLY  | apply pulse on amc_mode_o, settle counter loaded
// SETTLE | mapper settling after the mode change
// PASS   | frame bytes pass through combinationally until TLAST
module amc_frame_sched
  import amc_pkg::*;
#(
  parameter int unsigned          QDEPTH   = 4,
  parameter int unsigned          SETTLE   = 2,
  parameter logic [MODE_W-1:0]    DEF_MODE = 3'd0
) (
  input  logic              clk_bb,
  input  logic              rst,
  input  logic [MODE_W-1:0] req_mode,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [7:0]        m_data,
  output logic              m_last,
  output logic [MODE_W-1:0] amc_mode_o,
  output logic              amc_mode_valid_o,
  output logic [MODE_W-1:0] cur_mode,
  output logic              err_bad_mode,
  output logic              busy
`ifdef AMC_FRAME_SCHED_STATS_EN
  ,
  output logic [31:0]       stat_frames,
  output logic [31:0]       stat_bytes,
  output logic [15:0]       stat_def_used
`endif
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD =
    (SETTLE > 0) ? SETTLE_CNT_W'(SETTLE - 1) : '0;

  sched_state_e             state_q;
  logic [SETTLE_CNT_W-1:0]  settle_cnt_q;
  logic [MODE_W-1:0]        amc_mode_q;
  logic                     amc_mode_valid_q;
  logic [MODE_W-1:0]        cur_mode_q;
  logic                     err_bad_mode_q;

  logic                     fifo_push;
  logic                     fifo_pop;
  logic [MODE_W-1:0]        fifo_dout;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [CNT_W-1:0]         unused_fifo_count;

  logic                     frame_start;
  logic                     in_pass;
  logic                     beat;
  logic                     bad_pop_d;
  logic [MODE_W-1:0]        mode_sel_d;

  assign frame_start = (state_q == ST_IDLE) & s_valid;
  assign in_pass     = (state_q == ST_PASS);
  assign beat        = in_pass & s_valid & m_ready;

  assign req_ready = ~fifo_full;
  assign fifo_push = req_valid & req_ready;
  // The mode decision (and its pop) is committed on the IDLE->APPLY edge so
  // the registered pulse is already on the outputs during the APPLY cycle.
  // A push landing in that same cycle into an empty FIFO is left for the
  // next frame.
  assign fifo_pop  = frame_start & ~fifo_empty;

  always_comb begin
    bad_pop_d  = 1'b0;
    mode_sel_d = DEF_MODE;
    if (!fifo_empty) begin
      if (amc_mode_legal(fifo_dout)) begin
        mode_sel_d = fifo_dout;
      end else begin
        bad_pop_d  = 1'b1;
      end
    end
  end

  amc_mode_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (MODE_W)
  ) u_fifo (
    .clk_i   (clk_bb),
    .rst_i   (rst),
    .push_i  (fifo_push),
    .din_i   (req_mode),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count)
  );

  always_ff @(posedge clk_bb) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      settle_cnt_q     <= '0;
      amc_mode_q       <= DEF_MODE;
      amc_mode_valid_q <= 1'b0;
      cur_mode_q       <= DEF_MODE;
      err_bad_mode_q   <= 1'b0;
    end else begin
      amc_mode_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (s_valid) begin
            state_q          <= ST_APPLY;
            amc_mode_q       <= mode_sel_d;
            amc_mode_valid_q <= 1'b1;
            cur_mode_q       <= mode_sel_d;
            if (bad_pop_d) err_bad_mode_q <= 1'b1;
          end
        end
        ST_APPLY: begin
          if (SETTLE > 0) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= SETTLE_LOAD;
          end else begin
            state_q      <= ST_PASS;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt_q == '0) begin
            state_q <= ST_PASS;
          end else begin
            settle_cnt_q <= settle_cnt_q - SETTLE_CNT_W'(1);
          end
        end
        ST_PASS: begin
          if (beat & s_last) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign m_valid          = in_pass & s_valid;
  assign s_ready          = in_pass & m_ready;
  assign m_data           = in_pass ? s_data : 8'd0;
  assign m_last           = in_pass & s_last;
  assign amc_mode_o       = amc_mode_q;
  assign amc_mode_valid_o = amc_mode_valid_q;
  assign cur_mode         = cur_mode_q;
  assign err_bad_mode     = err_bad_mode_q;
  assign busy             = (state_q != ST_IDLE);

`ifdef AMC_FRAME_SCHED_STATS_EN
  logic [31:0] stat_frames_q;
  logic [31:0] stat_bytes_q;
  logic [15:0] stat_def_used_q;

  always_ff @(posedge clk_bb) begin
    if (rst) begin
      stat_frames_q   <= '0;
      stat_bytes_q    <= '0;
      stat_def_used_q <= '0;
    end else begin
      if (beat)                     stat_bytes_q    <= stat_bytes_q + 32'd1;
      if (beat & s_last)            stat_frames_q   <= stat_frames_q + 32'd1;
      if (frame_start & fifo_empty) stat_def_used_q <= stat_def_used_q + 16'd1;
    end
  end

  assign stat_frames   = stat_frames_q;
  assign stat_bytes    = stat_bytes_q;
  assign stat_def_used = stat_def_used_q;
`endif

endmodule

// File: tb/tb_amc_frame_sched.sv
module tb_amc_frame_sched;

  localparam int         QDEPTH_P = 4;
  localparam int         SETTLE_P = 3;
  localparam logic [2:0] DEF_P    = 3'd0;
  localparam int         EXP_LAT  = SETTLE_P + 2;

  logic       clk_bb = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req_mode = '0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] s_data = '0;
  logic       s_last = 1'b0;
  logic       m_valid;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last;
  logic [2:0] amc_mode_o;
  logic       amc_mode_valid_o;
  logic [2:0] cur_mode;
  logic       err_bad_mode;
  logic       busy;
`ifdef AMC_FRAME_SCHED_STATS_EN
  logic [31:0] stat_frames;
  logic [31:0] stat_bytes;
  logic [15:0] stat_def_used;
`endif

  int checks = 0;
  int errors = 0;
  int fnum = 0;

  // reference model state
  logic [2:0] mq[$];
  logic       exp_err = 1'b0;
  int         def_m = 0;
  int         frames_m = 0;
  int         bytes_m = 0;

  logic [8:0] mon_beats[$];
  logic [2:0] mon_pulses[$];

  amc_frame_sched #(
    .QDEPTH   (QDEPTH_P),
    .SETTLE   (SETTLE_P),
    .DEF_MODE (DEF_P)
  ) dut (
    .clk_bb           (clk_bb),
    .rst              (rst),
    .req_mode         (req_mode),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .s_valid          (s_valid),
    .s_ready          (s_ready),
    .s_data           (s_data),
    .s_last           (s_last),
    .m_valid          (m_valid),
    .m_ready          (m_ready),
    .m_data           (m_data),
    .m_last           (m_last),
    .amc_mode_o       (amc_mode_o),
    .amc_mode_valid_o (amc_mode_valid_o),
    .cur_mode         (cur_mode),
    .err_bad_mode     (err_bad_mode),
    .busy             (busy)
`ifdef AMC_FRAME_SCHED_STATS_EN
    ,
    .stat_frames      (stat_frames),
    .stat_bytes       (stat_bytes),
    .stat_def_used    (stat_def_used)
`endif
  );

  always #5 clk_bb = ~clk_bb;

  always @(negedge clk_bb) begin
    if (m_valid === 1'b1 && m_ready === 1'b1) mon_beats.push_back({m_last, m_data});
    if (amc_mode_valid_o === 1'b1) mon_pulses.push_back(amc_mode_o);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Mode the next frame must carry: queue head, or the default when empty;
  // reserved values fall back to the default and raise the sticky error.
  function automatic logic [2:0] model_next_mode();
    logic [2:0] m;
    if (mq.size() == 0) begin
      def_m++;
      return DEF_P;
    end
    m = mq.pop_front();
    if (m > 3'd1) begin
      exp_err = 1'b1;
      return DEF_P;
    end
    return m;
  endfunction

  task automatic model_clear();
    mq.delete();
    exp_err  = 1'b0;
    def_m    = 0;
    frames_m = 0;
    bytes_m  = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; req_valid = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk_bb);
    #2;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic push_req(input logic [2:0] m);
    int t;
    t = 0;
    req_mode = m; req_valid = 1'b1;
    do begin
      @(negedge clk_bb);
      t++;
    end while (req_ready !== 1'b1 && t < 50);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_req timeout: req_ready=%b want 1", req_ready);
    end else begin
      mq.push_back(m);
    end
    @(posedge clk_bb); #2;
    req_valid = 1'b0;
  endtask

  // Sends one frame and checks mode pulse, latency, byte stream and state.
  // mr_mode: 0 m_ready always 1, 1 alternating 1/0, 2 random.
  task automatic run_frame(input int n, input int mr_mode);
    logic [2:0] exp_mode;
    logic [7:0] bytes[$];
    logic [8:0] exp_b;
    int idx, cyc, lat, pulse_cyc, bad_pre, bad_mirror, nbad;
    fnum++;
    exp_mode = model_next_mode();
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
    mon_beats.delete();
    mon_pulses.delete();
    idx = 0; cyc = 0; lat = -1; pulse_cyc = -1; bad_pre = 0; bad_mirror = 0;
    while (idx < n && cyc < 300) begin
      s_valid = (lat < 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      s_data  = bytes[idx];
      s_last  = (idx == n - 1);
      case (mr_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ((cyc % 2) == 0);
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk_bb);
      if (amc_mode_valid_o === 1'b1 && pulse_cyc < 0) pulse_cyc = cyc;
      if (m_valid === 1'b1 && lat < 0) lat = cyc;
      if (lat >= 0) begin
        if (s_ready !== m_ready) bad_mirror++;
      end else if (s_ready !== 1'b0 || m_valid !== 1'b0) begin
        bad_pre++;
      end
      if (s_valid === 1'b1 && s_ready === 1'b1) idx++;
      cyc++;
      @(posedge clk_bb); #2;
    end
    s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b1;

    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL frame%0d completion: bytes accepted %0d want %0d", fnum, idx, n);
    end else begin
      frames_m++;
      bytes_m += n;
    end
    checks++;
    if (lat != EXP_LAT) begin
      errors++;
      $display("FAIL frame%0d latency: first m_valid at +%0d want +%0d", fnum, lat, EXP_LAT);
    end
    checks++;
    if (pulse_cyc != 1) begin
      errors++;
      $display("FAIL frame%0d pulse_time: amc_mode_valid_o at +%0d want +1", fnum, pulse_cyc);
    end
    checks++;
    if (mon_pulses.size() != 1 || mon_pulses[0] !== exp_mode) begin
      errors++;
      $display("FAIL frame%0d pulse_mode: pulses=%0d first=%0d want 1 pulse mode %0d",
               fnum, mon_pulses.size(), (mon_pulses.size() > 0) ? mon_pulses[0] : 3'd0, exp_mode);
    end
    nbad = 0;
    if (mon_beats.size() != n) begin
      nbad = 1;
    end else begin
      for (int i = 0; i < n; i++) begin
        exp_b = {(i == n - 1), bytes[i]};
        if (mon_beats[i] !== exp_b) nbad++;
      end
    end
    checks++;
    if (nbad != 0) begin
      errors++;
      $display("FAIL frame%0d bytes: got %0d beats with %0d wrong, want %0d exact beats",
               fnum, mon_beats.size(), nbad, n);
    end
    checks++;
    if (bad_pre != 0) begin
      errors++;
      $display("FAIL frame%0d pre_pass_stall: %0d cycles with s_ready/m_valid high before PASS, want 0",
               fnum, bad_pre);
    end
    checks++;
    if (bad_mirror != 0) begin
      errors++;
      $display("FAIL frame%0d ready_mirror: %0d cycles s_ready!=m_ready in PASS, want 0", fnum, bad_mirror);
    end
    @(negedge clk_bb);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL frame%0d idle_after_last: busy=%b want 0", fnum, busy);
    end
    checks++;
    if (cur_mode !== exp_mode || amc_mode_o !== exp_mode) begin
      errors++;
      $display("FAIL frame%0d held_mode: cur_mode=%0d amc_mode_o=%0d want %0d",
               fnum, cur_mode, amc_mode_o, exp_mode);
    end
    checks++;
    if (err_bad_mode !== exp_err) begin
      errors++;
      $display("FAIL frame%0d err_bad_mode: got %b want %b", fnum, err_bad_mode, exp_err);
    end
    @(posedge clk_bb); #2;
  endtask

  task automatic test_reset();
    @(negedge clk_bb);
    checks++;
    if (req_ready !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: req_ready=%b s_ready=%b m_valid=%b busy=%b want 1 0 0 0",
               req_ready, s_ready, m_valid, busy);
    end
    checks++;
    if (m_data !== 8'd0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mdata: m_data=%0h m_last=%b want 0 0", m_data, m_last);
    end
    checks++;
    if (amc_mode_o !== DEF_P || amc_mode_valid_o !== 1'b0 || cur_mode !== DEF_P) begin
      errors++;
      $display("FAIL reset_mode: amc_mode_o=%0d valid=%b cur_mode=%0d want %0d 0 %0d",
               amc_mode_o, amc_mode_valid_o, cur_mode, DEF_P, DEF_P);
    end
    checks++;
    if (err_bad_mode !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: err_bad_mode=%b want 0", err_bad_mode);
    end
    @(posedge clk_bb); #2;
  endtask

  task automatic test_basic();
    push_req(3'd1);
    push_req(3'd0);
    run_frame(4, 0);
    run_frame(4, 0);
  endtask

  task automatic test_default();
    run_frame(4, 0);
`ifdef AMC_FRAME_SCHED_STATS_EN
    checks++;
    if (stat_def_used !== 16'(def_m)) begin
      errors++;
      $display("FAIL stat_def_used: got %0d want %0d", stat_def_used, def_m);
    end
`endif
  endtask

  task automatic test_full();
    logic [2:0] m5;
    int stall_bad, t;
    for (int i = 0; i < QDEPTH_P; i++) push_req(3'($urandom_range(0, 1)));
    @(negedge clk_bb);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready: req_ready=%b want 0", req_ready);
    end
    @(posedge clk_bb); #2;
    m5 = 3'($urandom_range(0, 1));
    req_mode = m5; req_valid = 1'b1;
    stall_bad = 0;
    repeat (3) begin
      @(negedge clk_bb);
      if (req_ready !== 1'b0) stall_bad++;
      @(posedge clk_bb); #2;
    end
    checks++;
    if (stall_bad != 0) begin
      errors++;
      $display("FAIL full_stall: req_ready high %0d cycles while full, want 0", stall_bad);
    end
    fork
      run_frame(4, 0);
      begin
        t = 0;
        do begin
          @(negedge clk_bb);
          t++;
        end while (req_ready !== 1'b1 && t < 20);
        checks++;
        if (req_ready !== 1'b1) begin
          errors++;
          $display("FAIL full_accept: fifth request not accepted after pop, req_ready=%b", req_ready);
        end else begin
          mq.push_back(m5);
        end
        @(posedge clk_bb); #2;
        req_valid = 1'b0;
      end
    join
    for (int i = 0; i < QDEPTH_P; i++) run_frame(3 + i, 2);
  endtask

  task automatic test_bad_mode();
    push_req(3'd5);
    run_frame(4, 0);
    for (int i = 0; i < 3; i++) run_frame(2 + i, 2);
  endtask

  task automatic test_backpressure();
    push_req(3'd1);
    run_frame(6, 1);
    push_req(3'd0);
    push_req(3'd1);
    run_frame(5, 2);
    run_frame(1, 1);
  endtask

  task automatic test_rst_mid();
    logic [2:0] exp_mode;
    logic [7:0] b0, b1;
    int t;
    logic acc;
    push_req(3'd1);
    push_req(3'd1);
    exp_mode = model_next_mode();
    b0 = 8'($urandom); b1 = 8'($urandom);
    s_valid = 1'b1; s_data = b0; s_last = 1'b0; m_ready = 1'b1;
    t = 0;
    do begin
      @(negedge clk_bb);
      acc = (s_ready === 1'b1);
      t++;
      @(posedge clk_bb); #2;
    end while (!acc && t < 50);
    checks++;
    if (!acc || cur_mode !== exp_mode) begin
      errors++;
      $display("FAIL rst_mid_first_byte: accepted=%b cur_mode=%0d want 1 %0d", acc, cur_mode, exp_mode);
    end
    s_data = b1; rst = 1'b1;
    @(negedge clk_bb);
    checks++;
    if (m_valid !== 1'b1 || m_data !== b1) begin
      errors++;
      $display("FAIL rst_mid_second_byte: m_valid=%b m_data=%0h want 1 %0h", m_valid, m_data, b1);
    end
    @(posedge clk_bb); #2;
    rst = 1'b0; s_valid = 1'b0; s_data = '0;
    model_clear();
    @(negedge clk_bb);
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_state: m_valid=%b busy=%b req_ready=%b want 0 0 1", m_valid, busy, req_ready);
    end
    checks++;
    if (cur_mode !== DEF_P || amc_mode_o !== DEF_P || err_bad_mode !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_mode: cur_mode=%0d amc_mode_o=%0d err=%b want %0d %0d 0",
               cur_mode, amc_mode_o, err_bad_mode, DEF_P, DEF_P);
    end
    @(posedge clk_bb); #2;
    run_frame(4, 0);
  endtask

  task automatic test_stats();
`ifdef AMC_FRAME_SCHED_STATS_EN
    push_req(3'd1);
    run_frame(7, 2);
    run_frame(3, 0);
    checks++;
    if (stat_frames !== 32'(frames_m) || stat_bytes !== 32'(bytes_m) || stat_def_used !== 16'(def_m)) begin
      errors++;
      $display("FAIL stats: frames=%0d bytes=%0d def=%0d want %0d %0d %0d",
               stat_frames, stat_bytes, stat_def_used, frames_m, bytes_m, def_m);
    end
`else
    run_frame(3, 2);
`endif
  endtask

  initial begin
    do_reset();
    test_reset();
    test_basic();
    test_default();
    test_full();
    test_bad_mode();
    test_backpressure();
    test_rst_mid();
    test_stats();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
